// File: rtl/paquete_mips.sv
// Shared fetch-stage definitions: FSM states, opcodes and the NOP word.
package paquete_mips;

    typedef enum logic [1:0] {
        ARRANQUE,
        BUSCA,
        DETENIDO,
        DESCARTE
    } estado_t;

    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEF = 32'd4;

endpackage

// File: rtl/calc_siguiente_pc.sv
// Branch/jump target computation and redirect decision for an instruction
// held in a pipeline register; jump wins over branch.
module calc_siguiente_pc (
    input  logic        valid,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] pc4,
    input  logic [25:0] imm,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign branch_tgt = pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
    assign jump_tgt   = {pc4[31:28], imm, 2'b00};

    // valid gates first so unknown control bits on an empty slot are masked
    assign redirect = valid & ~stall & (jump | (branch & zero));
    assign target   = jump ? jump_tgt : branch_tgt;

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage with IF/ID register; owns the PC and talks to
// instruction memory over a req/ack handshake.
module etapa_busqueda
    import paquete_mips::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  op_code
);

    estado_t     state, state_n;
    logic [31:0] pc_n;
    logic [31:0] instr_n, pc4_n;
    logic        valid_n;
    logic [31:0] held_instr, held_instr_n;
    logic [31:0] held_pc4, held_pc4_n;
    logic [31:0] pend, pend_n;
    logic [31:0] fetch_pc4;
    logic        redirect;
    logic [31:0] target;

    calc_siguiente_pc u_calc (
        .valid    (if_id_valid),
        .stall    (stall),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
        .pc4      (if_id_pc4),
        .imm      (if_id_instr[25:0]),
        .redirect (redirect),
        .target   (target)
    );

    assign fetch_pc4 = pc + 32'd4;
    assign imem_req  = (state == BUSCA) || (state == DESCARTE);
    assign imem_addr = pc;
    assign op_code   = if_id_instr[31:26];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARRANQUE;
            pc          <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            held_instr  <= '0;
            held_pc4    <= '0;
            pend        <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_id_instr <= instr_n;
            if_id_pc4   <= pc4_n;
            if_id_valid <= valid_n;
            held_instr  <= held_instr_n;
            held_pc4    <= held_pc4_n;
            pend        <= pend_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = if_id_instr;
        pc4_n        = if_id_pc4;
        valid_n      = if_id_valid;
        held_instr_n = held_instr;
        held_pc4_n   = held_pc4;
        pend_n       = pend;
        unique case (state)
            ARRANQUE: state_n = BUSCA;
            BUSCA: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    instr_n = NOP_WORD;
                    if (imem_ack) begin
                        pc_n = target;
                    end else begin
                        // request already in flight: finish it, then jump
                        pend_n  = target;
                        state_n = DESCARTE;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
                        held_instr_n = imem_rdata;
                        held_pc4_n   = fetch_pc4;
                        pc_n         = pc + PC_INC;
                        state_n      = DETENIDO;
                    end
                end else if (imem_ack) begin
                    instr_n = imem_rdata;
                    pc4_n   = fetch_pc4;
                    valid_n = 1'b1;
                    pc_n    = pc + PC_INC;
                end else begin
                    valid_n = 1'b0;
                end
            end
            DETENIDO: begin
                if (!stall) begin
                    state_n = BUSCA;
                    if (redirect) begin
                        valid_n = 1'b0;
                        instr_n = NOP_WORD;
                        pc_n    = target;
                    end else begin
                        instr_n = held_instr;
                        pc4_n   = held_pc4;
                        valid_n = 1'b1;
                    end
                end
            end
            DESCARTE: begin
                if (imem_ack) begin
                    pc_n    = pend;
                    state_n = BUSCA;
                end
            end
            default: state_n = ARRANQUE;
        endcase
    end

endmodule

// File: tb/tb_etapa_busqueda.sv
// Scoreboard bench for etapa_busqueda: directed program with a
// latency-controlled instruction memory and a small control-unit model.
module tb_etapa_busqueda;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        zero;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op_code;

    logic [3:0]  wait_cnt;
    logic [3:0]  lat;
    int          n_pass;
    int          n_total;
    int          cyc;

    logic [31:0] q_addr[$];
    logic [63:0] q_ifid[$];

    etapa_busqueda #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .op_code     (op_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h2008_0005;
            32'h0C:  return 32'h1000_FFFF;
            32'h14:  return 32'h0800_0010;
            32'h44:  return 32'h0800_0020;
            32'h84:  return 32'hAC09_0000;
            32'h8C:  return 32'h0800_0030;
            default: return {16'h2000, a[15:0]};
        endcase
    endfunction

    // memory acks after lat wait cycles of a held request
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = word_at(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 4'd0;
        else                       wait_cnt <= wait_cnt + 4'd1;
    end

    // control-unit model
    assign jump   = (op_code == 6'b000010);
    assign branch = (op_code == 6'b000100);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic to_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic push_ifid(input logic [31:0] i, input logic [31:0] p);
        q_ifid.push_back({i, p});
    endtask

    // monitor: handshakes and newly loaded IF/ID contents
    initial begin
        logic        pv;
        logic [31:0] pi;
        logic [31:0] pp;
        logic [31:0] e;
        logic [63:0] e64;
        pv = 1'b0;
        pi = '0;
        pp = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (imem_req && imem_ack && q_addr.size() > 0) begin
                    e = q_addr.pop_front();
                    chk("fetch_addr", imem_addr, e);
                end
                if (if_id_valid && (!pv || if_id_instr != pi ||
                    if_id_pc4 != pp) && q_ifid.size() > 0) begin
                    e64 = q_ifid.pop_front();
                    chk("ifid_instr", if_id_instr, e64[63:32]);
                    chk("ifid_pc4", if_id_pc4, e64[31:0]);
                end
            end
            pv = if_id_valid;
            pi = if_id_instr;
            pp = if_id_pc4;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        reset   = 1'b1;
        stall   = 1'b0;
        zero    = 1'b1;
        lat     = 4'd0;

        foreach (q_addr[i]) q_addr.delete(i);
        q_addr = {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h0C,
                  32'h10, 32'h14, 32'h18, 32'h40, 32'h44, 32'h48,
                  32'h80, 32'h84, 32'h88, 32'h8C};
        push_ifid(32'h2008_0005, 32'h04);
        push_ifid(32'h2000_0004, 32'h08);
        push_ifid(32'h2000_0008, 32'h0C);
        push_ifid(32'h1000_FFFF, 32'h10);
        push_ifid(32'h1000_FFFF, 32'h10);
        push_ifid(32'h2000_0010, 32'h14);
        push_ifid(32'h0800_0010, 32'h18);
        push_ifid(32'h2000_0040, 32'h44);
        push_ifid(32'h0800_0020, 32'h48);
        push_ifid(32'h2000_0080, 32'h84);
        push_ifid(32'hAC09_0000, 32'h88);
        push_ifid(32'h2000_0088, 32'h8C);
        push_ifid(32'h0800_0030, 32'h90);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);

        reset = 1'b0;
        cyc   = 0;
        chk("arranque_req", {31'b0, imem_req}, 32'd0);
        to_cyc(1);
        chk("busca_req", {31'b0, imem_req}, 32'd1);
        chk("addr0", imem_addr, 32'h0);
        to_cyc(2);
        chk("addr4", imem_addr, 32'h4);
        chk("op_code", {26'b0, op_code}, 32'h08);
        chk("pc4_first", if_id_pc4, 32'h4);
        to_cyc(3);
        chk("addr8", imem_addr, 32'h8);

        to_cyc(6);
        zero = 1'b0;
        chk("beq_pc", pc, 32'h0C);
        chk("beq_flush", {31'b0, if_id_valid}, 32'd0);
        to_cyc(8);
        chk("beq_nt_valid", {31'b0, if_id_valid}, 32'd1);
        chk("beq_nt_pc", pc, 32'h14);
        to_cyc(10);
        chk("j_pc", pc, 32'h40);
        chk("j_flush", {31'b0, if_id_valid}, 32'd0);
        to_cyc(11);
        chk("j_resume", {31'b0, if_id_valid}, 32'd1);

        to_cyc(12);
        lat = 4'd2;
        to_cyc(13);
        chk("wait_req", {31'b0, imem_req}, 32'd1);
        chk("wait_addr1", imem_addr, 32'h48);
        chk("wait_flush", {31'b0, if_id_valid}, 32'd0);
        to_cyc(14);
        chk("wait_addr2", imem_addr, 32'h48);
        to_cyc(15);
        chk("redir_addr", imem_addr, 32'h80);
        chk("redir_req", {31'b0, imem_req}, 32'd1);

        to_cyc(18);
        lat   = 4'd0;
        stall = 1'b1;
        for (int k = 19; k <= 22; k++) begin
            to_cyc(k);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_hold", if_id_instr, 32'h2000_0080);
            if (k == 22) stall = 1'b0;
        end
        to_cyc(23);
        chk("unstall_instr", if_id_instr, 32'hAC09_0000);
        chk("unstall_pc", pc, 32'h88);
        chk("unstall_valid", {31'b0, if_id_valid}, 32'd1);

        to_cyc(25);
        lat = 4'd2;
        to_cyc(26);
        chk("descarte_req", {31'b0, imem_req}, 32'd1);
        chk("descarte_addr", imem_addr, 32'h90);
        q_addr.push_back(32'h00);
        q_addr.push_back(32'h04);
        q_addr.push_back(32'h08);
        push_ifid(32'h2008_0005, 32'h04);
        push_ifid(32'h2000_0004, 32'h08);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", {31'b0, if_id_valid}, 32'd0);
        lat = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        chk("rearranque_req", {31'b0, imem_req}, 32'd0);
        to_cyc(1);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        to_cyc(5);

        chk("addr_q_left", q_addr.size(), 32'd0);
        chk("ifid_q_left", q_ifid.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/etapa_busqueda.md
Name: etapa_busqueda

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of unidad_de_control.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Its registered instruction's bits [31:26] drive op_code into the control unit.
- Consumes the control unit's branch/jump outputs and the ID comparator's zero flag to redirect the PC, flush wrong-path instructions and honour hazard stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 32'd4, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall; holds PC and the IF/ID contents.
- branch  input  1  from unidad_de_control.
- jump  input  1  from unidad_de_control.
- zero  input  1  ID-stage register-equality result for beq.
- imem_req  output  1  fetch request, held until imem_ack.
- imem_addr  output  32  fetch address; equals pc.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- imem_ack  input  1  may be asserted in the same cycle as imem_req (zero-wait).
- pc  output  32  address of the next request.
- if_id_instr  output  32  registered instruction.
- if_id_pc4  output  32  registered (fetch address + 4).
- if_id_valid  output  1  IF/ID holds a real instruction.
- op_code  output  6  if_id_instr[31:26], combinational.

Behaviour:
- Clocking and reset: single clock, clk; reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, imem_req=0, state ARRANQUE, buffer and pending registers cleared.
- Reset asserted mid-transaction drops imem_req immediately; the memory must tolerate an abandoned request.
- redirect = if_id_valid & ~stall & (jump | (branch & zero)).
  - X on branch/jump while if_id_valid=0 is masked.
- Redirect targets (all arithmetic mod 2^32):
  - branch target = if_id_pc4 + (sign_extend(if_id_instr[15:0]) << 2).
  - jump target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
  - jump has priority over branch.
- Handshake: imem_req is high in BUSCA and DESCARTE; imem_addr stays stable while imem_req=1 and ack=0.
- States:
  - ARRANQUE: imem_req=0; goes to BUSCA next cycle.
  - BUSCA:
    - redirect: IF/ID flushed (if_id_valid<=0, if_id_instr<=0). If ack, rdata is discarded and pc<=target; otherwise pend<=target and go to DESCARTE.
    - else if stall and ack: rdata and pc+4 go into the buffer, pc<=pc+PC_INC, go to DETENIDO; IF/ID held.
    - else if stall, no ack: everything held.
    - else if ack: if_id_instr<=imem_rdata, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+PC_INC. Zero-wait memory therefore gives 1 instruction/cycle.
    - else (no ack): bubble, if_id_valid<=0.
  - DETENIDO: imem_req=0.
    - stall=1: hold.
    - stall=0 with redirect: buffer discarded, flush, pc<=target, go to BUSCA.
    - stall=0, no redirect: buffer moves into IF/ID with valid=1, go to BUSCA.
  - DESCARTE: on ack, rdata is dropped, pc<=pend, go to BUSCA; if_id_valid stays 0.
    - A redirect here is impossible because IF/ID is invalid.
- Latency: instruction fetched at address A appears in IF/ID on the edge of its ack cycle, so op_code is valid the following cycle.
- Flush inserts 0x00000000 (sll $0 NOP); unidad_de_control decodes this as R-type, but the datapath qualifies regWrite with if_id_valid.
- PC wraps from 0xFFFFFFFC to 0x00000000 with no error.

Decomposition:
- Shared package (paquete_mips): state encodings ARRANQUE/BUSCA/DETENIDO/DESCARTE, opcode constants (OP_J=6'b000010, OP_BEQ=6'b000100), NOP word, PC_INC.
- One natural sub-module, calc_siguiente_pc: combinational branch/jump target computation and redirect select, reused later by an EX-stage branch resolver.

Test Plan:
- Reset, then zero-wait memory returning 0x20080005 at 0: after ARRANQUE, imem_addr=0, then 4, 8 on consecutive cycles. IF/ID gets instr 0x20080005 with pc4=4; op_code=6'b001000.
- j with if_id_instr=0x08000010, jump=1: pc becomes 0x00000040 next cycle, if_id_valid=0 for one cycle, then the fetch at 0x40 proceeds.
- beq with offset 0xFFFF at pc4=0x10, branch=1, zero=1: target 0x0000000C. With zero=0, fetching stays sequential and there is no flush.
- Memory with 3-cycle ack while a redirect to 0x80 arrives in the first wait cycle: imem_addr stays constant until ack, the data is discarded, and the next request goes to 0x80.
- stall=1 for 4 cycles during an ack with rdata 0xAC090000: IF/ID is unchanged and imem_req=0 in DETENIDO. After stall drops, if_id_instr=0xAC090000 and pc has advanced by 4.
- Reset asserted while imem_req=1 in DESCARTE: imem_req=0 immediately, pc=RESET_PC, if_id_valid=0, and fetching restarts from ARRANQUE.
